store_buffer: RTL and testbench
===============================

STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, entry count; power of 2, minimum 2.
REQ-002 SHALL have parameter DATA_W, default 32, store data width; legal values 32 and 64. STRB_W = DATA_W/8 and OFS_W = log2(STRB_W).
REQ-003 SHALL have parameter ADDR_W, default 32, address width.
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port flush_i, input, 1, exception flush; discards uncommitted entries.
REQ-007 SHALL have port st_valid_i, input, 1, store request from EX.
REQ-008 SHALL have port st_ready_o, output, 1, buffer can accept a store.
REQ-009 SHALL have port st_addr_i, input, ADDR_W, store byte address.
REQ-010 SHALL have port st_size_i, input, 2, access size: 0 byte, 1 half, 2 word, 3 dword.
REQ-011 SHALL have port st_wdata_i, input, DATA_W, unreplicated store data, LSB-aligned.
REQ-012 SHALL have port st_ale_o, output, 1, combinational misalignment flag for the current request.
REQ-013 SHALL have port commit_i, input, 1, WB pulse; commits the oldest uncommitted entry.
REQ-014 SHALL have ports dc_valid_o (output, 1) and dc_ready_i (input, 1), the D-cache write handshake.
REQ-015 SHALL have ports dc_addr_o (output, ADDR_W), dc_wstrb_o (output, STRB_W) and dc_wdata_o (output, DATA_W), the head-entry write data.
REQ-016 SHALL have ports ld_valid_i (input, 1), ld_addr_i (input, ADDR_W) and ld_hit_o (output, 1), the load conflict check.
REQ-017 SHALL have ports empty_o (output, 1) and count_o (output, log2(DEPTH)+1), occupancy.

Function
REQ-018 SHALL generate the strobe by shifting the mask for st_size_i (1, 3, F or FF in hex) left by st_addr_i[OFS_W-1:0].
REQ-019 SHALL replicate st_wdata_i low bytes of the access size across DATA_W: byte replicated STRB_W times, half replicated STRB_W/2 times, and so on.
REQ-020 SHALL assert st_ale_o when st_valid_i is high and either the address low bits are not a multiple of 1<<st_size_i or st_size_i > OFS_W.
REQ-021 SHALL enqueue at tail on st_valid_i & st_ready_o & ~st_ale_o & ~flush_i; an entry holds addr, strobe, replicated data and committed=0.
REQ-022 SHALL drive st_ready_o = (count < DEPTH); a same-cycle dequeue does not open a full buffer.
REQ-023 SHALL, on commit_i, set committed on the entry at the commit pointer and advance that pointer; commit_i with no uncommitted entry is ignored.
REQ-024 SHALL drive dc_valid_o from registered state only: head entry valid and committed.
REQ-025 SHALL dequeue the head on dc_valid_o & dc_ready_i; dc_* outputs are held stable while dc_valid_o=1 and dc_ready_i=0.
REQ-026 SHALL drain in strict FIFO order, one entry per cycle maximum.
REQ-027 SHALL, on flush_i, set tail to the post-commit commit pointer and drop all uncommitted entries; committed entries keep draining.
REQ-028 SHALL resolve same-cycle events in order: commit_i first, then flush_i, with any enqueue discarded; simultaneous enqueue and dequeue leaves count unchanged.
REQ-029 SHALL wrap all pointers modulo DEPTH; count_o equals the number of valid entries, 0..DEPTH.
REQ-030 SHALL drive ld_hit_o combinationally: ld_valid_i and any valid entry with addr[ADDR_W-1:OFS_W] equal to ld_addr_i[ADDR_W-1:OFS_W]; the word-granular, conservative match ignores strobes.
REQ-031 SHALL drive empty_o = (count == 0).

Reset
REQ-032 SHALL, while rst_n=0 (asynchronous, including mid-drain), clear all entries and pointers and drive count_o=0, empty_o=1, st_ready_o=1, dc_valid_o=0, ld_hit_o=0, st_ale_o=0 and dc_addr_o/dc_wstrb_o/dc_wdata_o=0.
REQ-033 SHALL accept a store on the first rising clk edge after rst_n deasserts.

Verification (DEPTH=4, DATA_W=32)
REQ-034 SHALL cover: byte store to 0x1003, data 0xAB, then commit_i, dc_ready_i=1 -> the cycle after the commit edge, dc_valid_o=1, dc_addr_o=0x1003, dc_wstrb_o=1000, dc_wdata_o=0xABABABAB; empty_o=1 after.
REQ-035 SHALL cover: half store to 0x2001 -> st_ale_o=1, count_o stays 0; word store to 0x2002 -> st_ale_o=1.
REQ-036 SHALL cover: 4 stores without commit -> count_o=4, st_ready_o=0, 5th store refused; one commit and one drain -> count_o=3, st_ready_o=1.
REQ-037 SHALL cover: 3 stores, one commit, then commit_i and flush_i in the same cycle -> count_o=2; entries 1 and 2 drain in order, then empty_o=1.
REQ-038 SHALL cover: pending word store at 0x3000 -> ld_addr_i 0x3002 gives ld_hit_o=1; ld_addr_i 0x3004 gives ld_hit_o=0.
REQ-039 SHALL cover: rst_n low while dc_valid_o=1 and dc_ready_i=0 -> dc_valid_o=0 and count_o=0 without a clk edge.

Source files
------------

// File: rtl/store_buffer_if.sv
// Signal bundle between the core pipeline, the store buffer and the D-cache write port.
// The store buffer connects through the slave modport; the core/cache side uses master.
interface store_buffer_if #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    localparam int STRB_W = DATA_W / 8;
    localparam int CNT_W  = $clog2(DEPTH) + 1;

    logic              flush_i;
    logic              st_valid_i;
    logic              st_ready_o;
    logic [ADDR_W-1:0] st_addr_i;
    logic [1:0]        st_size_i;
    logic [DATA_W-1:0] st_wdata_i;
    logic              st_ale_o;
    logic              commit_i;
    logic              dc_valid_o;
    logic              dc_ready_i;
    logic [ADDR_W-1:0] dc_addr_o;
    logic [STRB_W-1:0] dc_wstrb_o;
    logic [DATA_W-1:0] dc_wdata_o;
    logic              ld_valid_i;
    logic [ADDR_W-1:0] ld_addr_i;
    logic              ld_hit_o;
    logic              empty_o;
    logic [CNT_W-1:0]  count_o;

    modport master (
        output flush_i, st_valid_i, st_addr_i, st_size_i, st_wdata_i, commit_i,
               dc_ready_i, ld_valid_i, ld_addr_i,
        input  st_ready_o, st_ale_o, dc_valid_o, dc_addr_o, dc_wstrb_o, dc_wdata_o,
               ld_hit_o, empty_o, count_o
    );

    modport slave (
        input  flush_i, st_valid_i, st_addr_i, st_size_i, st_wdata_i, commit_i,
               dc_ready_i, ld_valid_i, ld_addr_i,
        output st_ready_o, st_ale_o, dc_valid_o, dc_addr_o, dc_wstrb_o, dc_wdata_o,
               ld_hit_o, empty_o, count_o
    );
endinterface

// File: rtl/store_buffer.sv
// Circular store buffer: stores enqueue speculatively, become drainable once committed,
// and drain in order to the D-cache; a flush drops everything not yet committed.
module store_buffer #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    store_buffer_if.slave sb
);
    localparam int STRB_W = DATA_W / 8;
    localparam int OFS_W  = $clog2(STRB_W);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [1:0]       MAX_SIZE = 2'(OFS_W);

    function automatic logic [STRB_W-1:0] strobe(input logic [1:0] size, input logic [OFS_W-1:0] ofs);
        logic [7:0] mask;
        case (size)
            2'd0:    mask = 8'h01;
            2'd1:    mask = 8'h03;
            2'd2:    mask = 8'h0F;
            default: mask = 8'hFF;
        endcase
        return STRB_W'(mask) << ofs;
    endfunction

    // Lane b takes byte (b mod access-bytes) of the LSB-aligned store data.
    function automatic logic [DATA_W-1:0] replicate(input logic [DATA_W-1:0] d, input logic [1:0] size);
        logic [DATA_W-1:0] r;
        r = '0;
        for (int b = 0; b < STRB_W; b++) begin
            case (size)
                2'd0:    r[b*8 +: 8] = d[7:0];
                2'd1:    r[b*8 +: 8] = d[(b % 2) * 8 +: 8];
                2'd2:    r[b*8 +: 8] = d[(b % 4) * 8 +: 8];
                default: r[b*8 +: 8] = d[(b % 8) * 8 +: 8];
            endcase
        end
        return r;
    endfunction

    logic [DEPTH-1:0]  valid_r;
    logic [DEPTH-1:0]  committed_r;
    logic [ADDR_W-1:0] addr_r [DEPTH];
    logic [STRB_W-1:0] strb_r [DEPTH];
    logic [DATA_W-1:0] data_r [DEPTH];
    logic [PTR_W-1:0]  head_r;
    logic [PTR_W-1:0]  tail_r;
    logic [PTR_W-1:0]  cmt_r;
    logic [CNT_W-1:0]  count_r;

    logic [DEPTH-1:0]  valid_nxt_s;
    logic [DEPTH-1:0]  committed_nxt_s;
    logic [PTR_W-1:0]  head_nxt_s;
    logic [PTR_W-1:0]  tail_nxt_s;
    logic [PTR_W-1:0]  cmt_nxt_s;
    logic [CNT_W-1:0]  count_nxt_s;
    logic [OFS_W-1:0]  low_mask_s;
    logic              ready_s;
    logic              ale_s;
    logic              enq_s;
    logic              deq_s;
    logic              commit_s;
    logic              head_ok_s;
    logic              ld_match_s;
    logic              unused_ld_ofs_s;

    assign low_mask_s = OFS_W'((4'd1 << sb.st_size_i) - 4'd1);
    assign ale_s      = rst_n & sb.st_valid_i &
                        (((sb.st_addr_i[OFS_W-1:0] & low_mask_s) != '0) | (sb.st_size_i > MAX_SIZE));
    assign ready_s    = (count_r < DEPTH_C);
    assign enq_s      = sb.st_valid_i & ready_s & ~ale_s & ~sb.flush_i;
    assign head_ok_s  = valid_r[head_r] & committed_r[head_r];
    assign deq_s      = head_ok_s & sb.dc_ready_i;
    // The commit pointer always rests on the oldest uncommitted entry, if there is one.
    assign commit_s   = sb.commit_i & valid_r[cmt_r] & ~committed_r[cmt_r];

    assign sb.st_ready_o = ready_s;
    assign sb.st_ale_o   = ale_s;
    assign sb.dc_valid_o = head_ok_s;
    assign sb.dc_addr_o  = addr_r[head_r];
    assign sb.dc_wstrb_o = strb_r[head_r];
    assign sb.dc_wdata_o = data_r[head_r];
    assign sb.empty_o    = (count_r == '0);
    assign sb.count_o    = count_r;
    assign sb.ld_hit_o   = sb.ld_valid_i & ld_match_s;
    assign unused_ld_ofs_s = ^sb.ld_addr_i[OFS_W-1:0];

    // Next-state: commit, then dequeue, then flush (which overrides any enqueue).
    always_comb begin
        valid_nxt_s     = valid_r;
        committed_nxt_s = committed_r;
        head_nxt_s      = head_r;
        tail_nxt_s      = tail_r;
        cmt_nxt_s       = cmt_r;
        count_nxt_s     = '0;
        if (commit_s) begin
            committed_nxt_s[cmt_r] = 1'b1;
            cmt_nxt_s              = cmt_r + 1'b1;
        end else begin
            cmt_nxt_s = cmt_r;
        end
        if (deq_s) begin
            valid_nxt_s[head_r]     = 1'b0;
            committed_nxt_s[head_r] = 1'b0;
            head_nxt_s              = head_r + 1'b1;
        end else begin
            head_nxt_s = head_r;
        end
        if (sb.flush_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (!committed_nxt_s[i]) begin
                    valid_nxt_s[i] = 1'b0;
                end else begin
                    valid_nxt_s[i] = valid_nxt_s[i];
                end
            end
            tail_nxt_s = cmt_nxt_s;
        end else if (enq_s) begin
            valid_nxt_s[tail_r]     = 1'b1;
            committed_nxt_s[tail_r] = 1'b0;
            tail_nxt_s              = tail_r + 1'b1;
        end else begin
            tail_nxt_s = tail_r;
        end
        for (int i = 0; i < DEPTH; i++) begin
            count_nxt_s = count_nxt_s + CNT_W'(valid_nxt_s[i]);
        end
    end

    // Word-granular load conflict search over every valid entry.
    always_comb begin
        ld_match_s = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_r[i] && (addr_r[i][ADDR_W-1:OFS_W] == sb.ld_addr_i[ADDR_W-1:OFS_W])) begin
                ld_match_s = 1'b1;
            end else begin
                ld_match_s = ld_match_s;
            end
        end
    end

    // Buffer state and entry payload registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r     <= '0;
            committed_r <= '0;
            head_r      <= '0;
            tail_r      <= '0;
            cmt_r       <= '0;
            count_r     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_r[i] <= '0;
                strb_r[i] <= '0;
                data_r[i] <= '0;
            end
        end else begin
            valid_r     <= valid_nxt_s;
            committed_r <= committed_nxt_s;
            head_r      <= head_nxt_s;
            tail_r      <= tail_nxt_s;
            cmt_r       <= cmt_nxt_s;
            count_r     <= count_nxt_s;
            if (enq_s) begin
                addr_r[tail_r] <= sb.st_addr_i;
                strb_r[tail_r] <= strobe(sb.st_size_i, sb.st_addr_i[OFS_W-1:0]);
                data_r[tail_r] <= replicate(sb.st_wdata_i, sb.st_size_i);
            end
        end
    end
endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: directed scenarios plus random traffic against a queue-based model;
// a monitor scores every D-cache write handshake against the committed-store queue.
module tb_store_buffer;
    localparam int DEPTH  = 4;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  strb;
        logic [31:0] data;
    } ent_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    store_buffer_if #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) sb ();
    store_buffer #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n), .sb(sb)
    );

    ent_t exp_q[$];   // committed, awaiting drain (oldest first)
    ent_t pend_q[$];  // enqueued, not yet committed
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic is_ale(input logic [31:0] a, input logic [1:0] s);
        int n;
        n = 1 << s;
        return (s > 2'd2) || ((int'(a[1:0]) % n) != 0);
    endfunction

    function automatic logic [3:0] strb_of(input logic [31:0] a, input logic [1:0] s);
        int nb;
        int m;
        nb = 1 << s;
        m = ((1 << nb) - 1) << a[1:0];
        return m[3:0];
    endfunction

    function automatic logic [31:0] rep_of(input logic [31:0] d, input logic [1:0] s);
        logic [31:0] r;
        int nb;
        nb = 1 << s;
        for (int b = 0; b < 4; b++) r[b*8 +: 8] = d[(b % nb) * 8 +: 8];
        return r;
    endfunction

    function automatic logic model_hit(input logic [31:0] la);
        logic h;
        h = 1'b0;
        foreach (exp_q[i])  if (exp_q[i].addr[31:2] == la[31:2]) h = 1'b1;
        foreach (pend_q[i]) if (pend_q[i].addr[31:2] == la[31:2]) h = 1'b1;
        return h;
    endfunction

    // Called at posedge+1: check state, drive one cycle of inputs, update model, advance.
    task automatic step(input logic sv, input logic [31:0] sa, input logic [1:0] ssz,
                        input logic [31:0] sd, input logic cm, input logic fl,
                        input logic dr, input logic lv, input logic [31:0] la);
        int total;
        logic eale;
        total = exp_q.size() + pend_q.size();
        chk("count", 64'(sb.count_o), 64'(total));
        chk("empty", 64'(sb.empty_o), 64'(total == 0));
        chk("ready", 64'(sb.st_ready_o), 64'(total < DEPTH));
        chk("dc_valid", 64'(sb.dc_valid_o), 64'(exp_q.size() > 0));
        sb.st_valid_i = sv; sb.st_addr_i = sa; sb.st_size_i = ssz; sb.st_wdata_i = sd;
        sb.commit_i = cm; sb.flush_i = fl; sb.dc_ready_i = dr;
        sb.ld_valid_i = lv; sb.ld_addr_i = la;
        #1;
        eale = sv && is_ale(sa, ssz);
        chk("ale", 64'(sb.st_ale_o), 64'(eale));
        chk("ld_hit", 64'(sb.ld_hit_o), 64'(lv && model_hit(la)));
        if (cm && pend_q.size() > 0) exp_q.push_back(pend_q.pop_front());
        if (fl) pend_q.delete();
        else if (sv && total < DEPTH && !eale)
            pend_q.push_back('{addr: sa, strb: strb_of(sa, ssz), data: rep_of(sd, ssz)});
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [1:0] s, input logic [31:0] d, input logic dr);
        step(1'b1, a, s, d, 1'b0, 1'b0, dr, 1'b0, 32'h0);
    endtask

    task automatic ctl(input logic cm, input logic fl, input logic dr);
        step(1'b0, 32'h0, 2'd0, 32'h0, cm, fl, dr, 1'b0, 32'h0);
    endtask

    task automatic drain_all();
        for (int i = 0; i < 40 && (exp_q.size() + pend_q.size()) > 0; i++) ctl(1'b1, 1'b0, 1'b1);
        chk("drain_complete", 64'(exp_q.size() + pend_q.size()), 64'd0);
    endtask

    // Monitor: every accepted D-cache write must match the oldest committed store.
    initial begin
        ent_t e;
        forever begin
            @(negedge clk);
            if (rst_n && sb.dc_valid_o && sb.dc_ready_i) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL drain_unexpected actual=%0h required=none", sb.dc_addr_o);
                end else begin
                    e = exp_q.pop_front();
                    chk("dc_addr", 64'(sb.dc_addr_o), 64'(e.addr));
                    chk("dc_wstrb", 64'(sb.dc_wstrb_o), 64'(e.strb));
                    chk("dc_wdata", 64'(sb.dc_wdata_o), 64'(e.data));
                end
            end
        end
    end

    initial begin
        logic sv, cm, fl, dr, lv;
        sb.flush_i = 1'b0; sb.commit_i = 1'b0; sb.dc_ready_i = 1'b0;
        sb.st_valid_i = 1'b1; sb.st_addr_i = 32'h1; sb.st_size_i = 2'd2; sb.st_wdata_i = 32'h0;
        sb.ld_valid_i = 1'b1; sb.ld_addr_i = 32'h0;
        #3;
        chk("rst_count", 64'(sb.count_o), 64'd0);
        chk("rst_empty", 64'(sb.empty_o), 64'd1);
        chk("rst_ready", 64'(sb.st_ready_o), 64'd1);
        chk("rst_dc_valid", 64'(sb.dc_valid_o), 64'd0);
        chk("rst_ale", 64'(sb.st_ale_o), 64'd0);
        chk("rst_ld_hit", 64'(sb.ld_hit_o), 64'd0);
        chk("rst_dc_addr", 64'(sb.dc_addr_o), 64'd0);
        chk("rst_dc_wdata", 64'(sb.dc_wdata_o), 64'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;

        // Byte store, commit, drain: replicated data and high-lane strobe.
        store(32'h1003, 2'd0, 32'h0000_00AB, 1'b1);
        ctl(1'b1, 1'b0, 1'b1);
        chk("byte_dc_valid", 64'(sb.dc_valid_o), 64'd1);
        chk("byte_dc_addr", 64'(sb.dc_addr_o), 64'h1003);
        chk("byte_dc_wstrb", 64'(sb.dc_wstrb_o), 64'b1000);
        chk("byte_dc_wdata", 64'(sb.dc_wdata_o), 64'hABAB_ABAB);
        ctl(1'b0, 1'b0, 1'b1);
        chk("byte_empty_after", 64'(sb.empty_o), 64'd1);

        // Misaligned half and word stores are flagged and not enqueued.
        store(32'h2001, 2'd1, 32'h1234, 1'b1);
        store(32'h2002, 2'd2, 32'h5678, 1'b1);
        chk("ale_count", 64'(sb.count_o), 64'd0);

        // Fill to capacity, refuse a fifth, then free one slot.
        for (int i = 0; i < 4; i++) store(32'h5000 + 32'(i * 4), 2'd2, $urandom, 1'b0);
        chk("full_count", 64'(sb.count_o), 64'd4);
        chk("full_ready", 64'(sb.st_ready_o), 64'd0);
        store(32'h5010, 2'd2, 32'hDEAD_BEEF, 1'b0);
        ctl(1'b1, 1'b0, 1'b0);
        ctl(1'b0, 1'b0, 1'b1);
        chk("after_drain_count", 64'(sb.count_o), 64'd3);
        chk("after_drain_ready", 64'(sb.st_ready_o), 64'd1);
        drain_all();

        // Commit and flush in the same cycle keep two committed entries.
        store(32'h6000, 2'd2, 32'h1111_1111, 1'b0);
        store(32'h6004, 2'd1, 32'h0000_2222, 1'b0);
        store(32'h6008, 2'd0, 32'h0000_0033, 1'b0);
        ctl(1'b1, 1'b0, 1'b0);
        ctl(1'b1, 1'b1, 1'b0);
        chk("flush_count", 64'(sb.count_o), 64'd2);
        ctl(1'b0, 1'b0, 1'b1);
        ctl(1'b0, 1'b0, 1'b1);
        chk("flush_empty", 64'(sb.empty_o), 64'd1);

        // Load conflict check is word-granular.
        store(32'h3000, 2'd2, 32'hCAFE_F00D, 1'b0);
        sb.ld_valid_i = 1'b1; sb.ld_addr_i = 32'h3002;
        #1;
        chk("ld_hit_same_word", 64'(sb.ld_hit_o), 64'd1);
        sb.ld_addr_i = 32'h3004;
        #1;
        chk("ld_hit_next_word", 64'(sb.ld_hit_o), 64'd0);
        ctl(1'b0, 1'b1, 1'b0);

        // Asynchronous reset while a drain is stalled.
        store(32'h7000, 2'd2, 32'h7777_7777, 1'b0);
        ctl(1'b1, 1'b0, 1'b0);
        chk("stall_dc_valid", 64'(sb.dc_valid_o), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_dc_valid", 64'(sb.dc_valid_o), 64'd0);
        chk("async_rst_count", 64'(sb.count_o), 64'd0);
        chk("async_rst_dc_addr", 64'(sb.dc_addr_o), 64'd0);
        exp_q.delete();
        pend_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        store(32'h7100, 2'd0, 32'h0000_0042, 1'b1);
        chk("first_edge_accept", 64'(sb.count_o), 64'd1);

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            sv = ($urandom_range(0, 9) < 6);
            cm = ($urandom_range(0, 9) < 3);
            fl = ($urandom_range(0, 19) == 0);
            dr = ($urandom_range(0, 9) < 7);
            lv = ($urandom_range(0, 1) == 1);
            step(sv, 32'h4000 + 32'($urandom_range(0, 31)), 2'($urandom_range(0, 3)), $urandom,
                 cm, fl, dr, lv, 32'h4000 + 32'($urandom_range(0, 39)));
        end
        drain_all();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
